// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multi-cycle MIPS datapath.
// Ports: clk_i/reset_i (sync, active-high); opcode_i = IR[31:26]; zero_i = ALU zero;
// mem_ready_i = shared memory completes this cycle. Outputs drive datapath selects,
// PC/IR/regfile write enables, memory strobes, done/illegal pulses and state_o for debug.
module multicycle_control (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_op_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
    } state_t;
    state_t state, state_nx;
    logic is_r, is_lw, is_sw, is_imm, is_beq, is_bne, is_j;
    assign is_r   = opcode_i == 6'h00;
    assign is_lw  = opcode_i == 6'h23;
    assign is_sw  = opcode_i == 6'h2b;
    assign is_imm = opcode_i == 6'h08 || opcode_i == 6'h0c || opcode_i == 6'h0d || opcode_i == 6'h0f;
    assign is_beq = opcode_i == 6'h04;
    assign is_bne = opcode_i == 6'h05;
    assign is_j   = opcode_i == 6'h02;
    assign state_o = state;
    always_ff @(posedge clk_i)
        state <= reset_i ? IDLE : state_nx;
    always_comb begin
        pc_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_src_o     = 2'b00;
        alu_op_o     = 3'b000;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        state_nx     = IDLE;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                alu_op_o    = 3'b100;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                state_nx    = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                // PC + (imm<<2) lands in ALUOut for a possible branch
                alu_src_b_o = 2'b11;
                alu_op_o    = 3'b100;
                illegal_o   = !(is_lw || is_sw || is_r || is_imm || is_beq || is_bne || is_j);
                state_nx    = (is_lw || is_sw) ? MEM_ADDR :
                              is_r             ? R_EXEC   :
                              is_imm           ? I_EXEC   :
                              (is_beq || is_bne) ? BRANCH :
                              is_j             ? JUMP     : FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 3'b100;
                state_nx    = is_lw ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                state_nx   = mem_ready_i ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
                state_nx     = FETCH;
            end
            MEM_WRITE: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
                state_nx     = mem_ready_i ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b111;
                state_nx    = R_WB;
            end
            R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
                state_nx     = FETCH;
            end
            I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = opcode_i == 6'h0c ? 3'b001 :
                              opcode_i == 6'h0d ? 3'b101 :
                              opcode_i == 6'h0f ? 3'b110 : 3'b100;
                state_nx    = I_WB;
            end
            I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_nx     = FETCH;
            end
            BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 3'b010;
                pc_src_o     = 2'b01;
                pc_write_o   = (is_beq && zero_i) || (is_bne && !zero_i);
                instr_done_o = 1'b1;
                state_nx     = FETCH;
            end
            JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                state_nx     = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + random instruction sequences checked against a per-instruction cycle model.
module tb_multicycle_control;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [5:0] opcode_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o;
    logic       mem_to_reg_o, reg_write_o, alu_src_a_o, instr_done_o, illegal_o;
    logic [1:0] alu_src_b_o, pc_src_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
    int         total = 0;
    int         bad = 0;

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b, pc_src;
        logic [2:0] alu_op;
        logic       done, illegal;
        logic [3:0] st;
    } ov_t;
    typedef struct {
        ov_t  e;
        logic rdy, z, rst;
    } step_t;

    ov_t got;
    assign got = '{pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
                   reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o, instr_done_o, illegal_o, state_o};

    multicycle_control dut (
        .clk_i(clk_i), .reset_i(reset_i), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .instr_done_o(instr_done_o),
        .illegal_o(illegal_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ov_t base(input int st);
        ov_t o = '0;
        o.st = 4'(st);
        return o;
    endfunction

    task automatic chk(input ov_t e, input string tag, input int k);
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s step %0d got=%h exp=%h", tag, k, got, e);
        end
    endtask

    // Builds the expected cycle-by-cycle trace of one instruction from its class,
    // wait counts and branch condition, then drives it and checks every cycle.
    // rst_at >= 0 aborts a store by asserting reset in that MEM_WRITE cycle.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z,
                             input int rst_at, input string tag);
        step_t q[$];
        ov_t   o;
        logic  lw, sw, r, imm, br, j;
        lw  = op == 6'h23;
        sw  = op == 6'h2b;
        r   = op == 6'h00;
        imm = op == 6'h08 || op == 6'h0c || op == 6'h0d || op == 6'h0f;
        br  = op == 6'h04 || op == 6'h05;
        j   = op == 6'h02;
        for (int i = 0; i <= fw; i++) begin
            o = base(1); o.mem_read = 1'b1; o.src_b = 2'b01; o.alu_op = 3'b100;
            o.ir_write = (i == fw); o.pc_write = (i == fw);
            q.push_back('{e: o, rdy: (i == fw), z: rb(), rst: 1'b0});
        end
        o = base(2); o.src_b = 2'b11; o.alu_op = 3'b100;
        o.illegal = !(lw || sw || r || imm || br || j);
        q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        if (lw || sw) begin
            o = base(3); o.src_a = 1'b1; o.src_b = 2'b10; o.alu_op = 3'b100;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        end
        if (lw) begin
            for (int i = 0; i <= mw; i++) begin
                o = base(4); o.mem_read = 1'b1; o.iord = 1'b1;
                q.push_back('{e: o, rdy: (i == mw), z: rb(), rst: 1'b0});
            end
            o = base(5); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.done = 1'b1;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        end
        if (sw && rst_at < 0) begin
            for (int i = 0; i <= mw; i++) begin
                o = base(6); o.mem_write = 1'b1; o.iord = 1'b1; o.done = (i == mw);
                q.push_back('{e: o, rdy: (i == mw), z: rb(), rst: 1'b0});
            end
        end
        if (sw && rst_at >= 0) begin
            for (int i = 0; i <= rst_at; i++) begin
                o = base(6); o.mem_write = 1'b1; o.iord = 1'b1;
                q.push_back('{e: o, rdy: 1'b0, z: rb(), rst: (i == rst_at)});
            end
            q.push_back('{e: base(0), rdy: rb(), z: rb(), rst: 1'b0});
        end
        if (r) begin
            o = base(7); o.src_a = 1'b1; o.alu_op = 3'b111;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
            o = base(8); o.reg_write = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        end
        if (imm) begin
            o = base(9); o.src_a = 1'b1; o.src_b = 2'b10;
            o.alu_op = op == 6'h08 ? 3'b100 : op == 6'h0c ? 3'b001 : op == 6'h0d ? 3'b101 : 3'b110;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
            o = base(10); o.reg_write = 1'b1; o.done = 1'b1;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        end
        if (br) begin
            o = base(11); o.src_a = 1'b1; o.alu_op = 3'b010; o.pc_src = 2'b01; o.done = 1'b1;
            o.pc_write = op == 6'h04 ? z : !z;
            q.push_back('{e: o, rdy: rb(), z: z, rst: 1'b0});
        end
        if (j) begin
            o = base(12); o.pc_src = 2'b10; o.pc_write = 1'b1; o.done = 1'b1;
            q.push_back('{e: o, rdy: rb(), z: rb(), rst: 1'b0});
        end
        foreach (q[k]) begin
            opcode_i    = op;
            mem_ready_i = q[k].rdy;
            zero_i      = q[k].z;
            reset_i     = q[k].rst;
            @(negedge clk_i);
            chk(q[k].e, tag, k);
            @(posedge clk_i);
            #1;
        end
        reset_i = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [12];
        ops = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f, 6'h11};
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = rb();
            @(negedge clk_i);
            chk(base(0), "reset", i);
            @(posedge clk_i);
            #1;
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        chk(base(0), "post_reset", 0);
        @(posedge clk_i);
        #1;
        run_instr(6'h08, 0, 0, 1'b0, -1, "addi");
        run_instr(6'h23, 2, 2, 1'b0, -1, "lw_wait");
        run_instr(6'h04, 0, 0, 1'b1, -1, "beq_z1");
        run_instr(6'h05, 0, 0, 1'b1, -1, "bne_z1");
        run_instr(6'h3f, 0, 0, 1'b0, -1, "illegal");
        run_instr(6'h00, 1, 0, 1'b0, -1, "rtype");
        run_instr(6'h02, 0, 0, 1'b0, -1, "jump");
        run_instr(6'h2b, 0, 0, 1'b0, 1, "sw_reset");
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 11)], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      rb(), -1, "random");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle build of the MIPS processor. Steps each instruction through fetch, decode, execute, memory and write-back states, driving the datapath mux selects, register/PC/IR write enables and the memory read/write strobes. It holds the shared memory port through a ready handshake, so the single instruction/data memory can insert wait states. Opcode coverage matches the single-cycle control unit plus load, store, branch and jump.

## Interface
- No parameters.
- clk_i  in  1  system clock, all state changes on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- opcode_i  in  6  IR[31:26]; stable from DECODE until the next fetch completes.
- zero_i  in  1  ALU zero flag; sampled only in BRANCH.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  PC load enable.
- iord_o  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read_o / mem_write_o  out  1 each  memory strobes, held until mem_ready_i.
- ir_write_o  out  1  IR load enable.
- reg_dst_o  out  1  destination select: 1=rd, 0=rt.
- mem_to_reg_o  out  1  write-back source: 1=MDR, 0=ALUOut.
- reg_write_o  out  1  register file write enable.
- alu_src_a_o  out  1  0=PC, 1=register A.
- alu_src_b_o  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_src_o  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_op_o  out  3  111=R-type funct, 100=ADD, 010=SUB, 101=OR, 001=AND, 110=LUI.
- instr_done_o  out  1  one-cycle pulse in an instruction's final cycle.
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
- Moore state register with combinational output decode.
  - Outputs depend on state.
  - Qualified by mem_ready_i: ir_write_o, pc_write_o, instr_done_o.
  - Qualified by opcode_i/zero_i where stated.
  - Every output not listed for a state is 0.
- Supported opcodes: R 0x00, ADDI 0x08, ANDI 0x0c, ORI 0x0d, LUI 0x0f, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02.
- State encoding and behaviour:
  - 0 IDLE: all outputs 0. Next state FETCH.
  - 1 FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=100.
    - When mem_ready_i=1: ir_write=1, pc_write=1, pc_src=00, next DECODE.
    - Otherwise stay in FETCH.
  - 2 DECODE: src_a=0, src_b=11, alu_op=100 (branch target into ALUOut).
    - LW/SW go to MEM_ADDR; R goes to R_EXEC; ADDI/ANDI/ORI/LUI go to I_EXEC.
    - BEQ/BNE go to BRANCH; J goes to JUMP.
    - Any other opcode: illegal=1, next FETCH.
  - 3 MEM_ADDR: src_a=1, src_b=10, alu_op=100. LW goes to MEM_READ, SW goes to MEM_WRITE.
  - 4 MEM_READ: mem_read=1, iord=1. Go to MEM_WB on mem_ready_i, else stay.
  - 5 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next FETCH.
  - 6 MEM_WRITE: mem_write=1, iord=1.
    - On mem_ready_i: instr_done=1, next FETCH.
    - Otherwise stay.
  - 7 R_EXEC: src_a=1, src_b=00, alu_op=111. Next R_WB.
  - 8 R_WB: reg_write=1, reg_dst=1, instr_done=1. Next FETCH.
  - 9 I_EXEC: src_a=1, src_b=10, alu_op from opcode (ADDI 100, ANDI 001, ORI 101, LUI 110). Next I_WB.
  - 10 I_WB: reg_write=1, reg_dst=0, instr_done=1. Next FETCH.
  - 11 BRANCH: src_a=1, src_b=00, alu_op=010, pc_src=01, instr_done=1. Next FETCH.
    - pc_write=(BEQ&zero_i)|(BNE&~zero_i).
  - 12 JUMP: pc_src=10, pc_write=1, instr_done=1. Next FETCH.
  - 13–15: unreachable. All outputs 0, next IDLE.
- mem_ready_i is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Timing
- A reset_i high at a rising edge puts the state in IDLE.
  - All outputs are 0 the following cycle. state_o=0.
  - FETCH begins one cycle after reset_i is sampled low.
- Reset mid-operation, including during a memory wait, abandons the instruction.
  - No write enable asserts after the reset edge.
  - The strobe drops in the cycle after the edge.
- Cycle counts with zero wait states:
  - LW 5; SW, R-type and I-type 4; BEQ/BNE/J 3.
  - Each memory wait cycle adds 1.
- Memory strobes stay asserted, with a stable iord_o, every cycle until mem_ready_i is sampled high. They deassert the next cycle.
- Write-back instructions assert reg_write_o for exactly one cycle.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 and state_o=0 while reset_i is high and for 1 cycle after; then mem_read_o=1 and state_o=1.
- ADDI (0x08), mem_ready_i tied 1: states 1,2,9,10; alu_op_o=100 in I_EXEC; reg_write_o=1 and reg_dst_o=0 in the 4th cycle; instr_done_o pulses once.
- LW with 2 wait cycles on both accesses: FETCH lasts 3 cycles, MEM_READ lasts 3 cycles, total 9 cycles; ir_write_o and pc_write_o high only in the last FETCH cycle; mem_to_reg_o=1 in MEM_WB.
- BEQ with zero_i=1, then BNE with zero_i=1: pc_write_o=1 with pc_src_o=01 for BEQ; pc_write_o=0 for BNE; each takes 3 cycles.
- Opcode 0x3f: illegal_o pulses in DECODE; next state FETCH; no reg_write_o or mem_write_o assertion.
- SW with mem_ready_i low, reset_i asserted on the 2nd MEM_WRITE cycle: mem_write_o=0 and state_o=0 the next cycle; instr_done_o never pulses.
